// File: rtl/fetch_stage_pkg.sv
// Shared constants and the IF/ID payload type for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;

    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register with write enable and flush-to-bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   we,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush wins over a stalled write so a bubble is always inserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (flush) begin
            q <= '{pc4: d.pc4, instr: NOP_INSTR, valid: 1'b0};
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+4 adder, post-reset init window and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned        INIT_CYCLES = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IIWrite,
    input  logic               flush,
    input  logic               PCSrc,
    input  logic [INSTR_W-1:0] BranchTarget,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [INSTR_W-1:0] IMemAddr,
    output logic [INSTR_W-1:0] II_PC4,
    output logic [INSTR_W-1:0] II_Instr,
    output logic               II_Valid,
    output logic               initi
);

    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_plus4;
    logic [CNT_W-1:0]   init_cnt;
    if_id_t             if_id_d;
    if_id_t             if_id_q;

    assign pc_plus4 = pc + INSTR_W'(4);
    assign IMemAddr = pc;

    // Flush holds the PC so the fall-through at branch+4 survives a not-taken branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (PCSrc) begin
            pc <= BranchTarget;
        end else if (flush) begin
            pc <= pc;
        end else if (PCWrite) begin
            pc <= pc_plus4;
        end
    end

    // initi follows the pre-decrement count, giving INIT_CYCLES high cycles after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt <= CNT_W'(INIT_CYCLES);
            initi    <= 1'b1;
        end else begin
            initi <= (init_cnt != '0);
            if (init_cnt != '0) begin
                init_cnt <= init_cnt - CNT_W'(1);
            end
        end
    end

    assign if_id_d = '{pc4: pc_plus4, instr: IMemData, valid: 1'b1};

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk  (clk),
        .reset(reset),
        .we   (IIWrite),
        .flush(PCSrc | flush),
        .d    (if_id_d),
        .q    (if_id_q)
    );

    assign II_PC4   = if_id_q.pc4;
    assign II_Instr = if_id_q.instr;
    assign II_Valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a combinational instruction memory.
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        pw;
        logic        iw;
        logic        fl;
        logic        ps;
        logic [31:0] bt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ia;
        logic        v;
        logic        ini;
    } vec_t;

    localparam int NV = 37;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b0;
    logic        IIWrite = 1'b0;
    logic        flush = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] IMemData;
    logic [31:0] IMemAddr;
    logic [31:0] II_PC4;
    logic [31:0] II_Instr;
    logic        II_Valid;
    logic        initi;

    int checks = 0;
    int failures = 0;
    vec_t vecs [NV];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .PCWrite     (PCWrite),
        .IIWrite     (IIWrite),
        .flush       (flush),
        .PCSrc       (PCSrc),
        .BranchTarget(BranchTarget),
        .IMemData    (IMemData),
        .IMemAddr    (IMemAddr),
        .II_PC4      (II_PC4),
        .II_Instr    (II_Instr),
        .II_Valid    (II_Valid),
        .initi       (initi)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign IMemData = instr_of(IMemAddr);

    function automatic vec_t mk(input logic rst, input logic pw, input logic iw, input logic fl,
                                input logic ps, input logic [31:0] bt, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic [31:0] ia, input logic v,
                                input logic ini);
        vec_t r;
        r.rst = rst; r.pw = pw; r.iw = iw; r.fl = fl; r.ps = ps; r.bt = bt;
        r.pc = pc; r.pc4 = pc4; r.ia = ia; r.v = v; r.ini = ini;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic pw, input logic iw, input logic fl,
                         input logic ps, input logic [31:0] bt);
        @(negedge clk);
        reset = rst; PCWrite = pw; IIWrite = iw; flush = fl; PCSrc = ps; BranchTarget = bt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_init;
        //            rst pw iw fl ps  bt            pc            pc4           ia            v  initi
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1);
        vecs[1]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h0,        1, 1);
        vecs[2]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h4,        1, 1);
        vecs[3]  = mk(0, 1, 1, 0, 0, 32'h0,        32'hC,        32'hC,        32'h8,        1, 1);
        vecs[4]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h10,       32'h10,       32'hC,        1, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h10,       32'h10,       32'hC,        1, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h14,       32'h14,       32'h10,       1, 0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h18,       32'h18,       32'h14,       1, 0);
        vecs[8]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h1C,       32'h1C,       32'h18,       1, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 32'h0,        32'h20,       32'h20,       32'h1C,       1, 0);
        vecs[10] = mk(0, 1, 1, 0, 0, 32'h0,        32'h24,       32'h24,       32'h20,       1, 0);
        vecs[11] = mk(0, 1, 1, 1, 0, 32'h0,        32'h24,       32'h28,       32'h0,        0, 0);
        vecs[12] = mk(0, 1, 1, 1, 0, 32'h0,        32'h24,       32'h28,       32'h0,        0, 0);
        vecs[13] = mk(0, 1, 1, 1, 1, 32'h100,      32'h100,      32'h28,       32'h0,        0, 0);
        vecs[14] = mk(0, 1, 1, 0, 0, 32'h0,        32'h104,      32'h104,      32'h100,      1, 0);
        vecs[15] = mk(0, 1, 1, 0, 0, 32'h0,        32'h108,      32'h108,      32'h104,      1, 0);
        vecs[16] = mk(0, 1, 1, 1, 0, 32'h0,        32'h108,      32'h10C,      32'h0,        0, 0);
        vecs[17] = mk(0, 1, 1, 1, 0, 32'h0,        32'h108,      32'h10C,      32'h0,        0, 0);
        vecs[18] = mk(0, 1, 1, 1, 0, 32'h0,        32'h108,      32'h10C,      32'h0,        0, 0);
        vecs[19] = mk(0, 1, 1, 0, 0, 32'h0,        32'h10C,      32'h10C,      32'h108,      1, 0);
        vecs[20] = mk(0, 0, 1, 0, 1, 32'h200,      32'h200,      32'h110,      32'h0,        0, 0);
        vecs[21] = mk(0, 1, 1, 0, 0, 32'h0,        32'h204,      32'h204,      32'h200,      1, 0);
        vecs[22] = mk(0, 0, 0, 1, 0, 32'h0,        32'h204,      32'h208,      32'h0,        0, 0);
        vecs[23] = mk(0, 1, 1, 0, 0, 32'h0,        32'h208,      32'h208,      32'h204,      1, 0);
        vecs[24] = mk(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h20C,    32'h0,        0, 0);
        vecs[25] = mk(0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, 1, 0);
        vecs[26] = mk(0, 1, 1, 0, 1, 32'h303,      32'h303,      32'h4,        32'h0,        0, 0);
        vecs[27] = mk(0, 1, 1, 0, 0, 32'h0,        32'h307,      32'h307,      32'h303,      1, 0);
        vecs[28] = mk(1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1);
        vecs[29] = mk(0, 1, 1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h0,        1, 1);
        vecs[30] = mk(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h4,        1, 1);
        vecs[31] = mk(1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 1);
        vecs[32] = mk(0, 1, 1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h0,        1, 1);
        vecs[33] = mk(0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h4,        1, 1);
        vecs[34] = mk(0, 1, 1, 0, 0, 32'h0,        32'hC,        32'hC,        32'h8,        1, 1);
        vecs[35] = mk(0, 1, 1, 0, 0, 32'h0,        32'h10,       32'h10,       32'hC,        1, 1);
        vecs[36] = mk(0, 1, 1, 0, 0, 32'h0,        32'h14,       32'h14,       32'h10,       1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].ps, vecs[i].bt);
            chk("pc", i, IMemAddr, vecs[i].pc);
            chk("ii_pc4", i, II_PC4, vecs[i].pc4);
            chk("ii_instr", i, II_Instr, vecs[i].v ? instr_of(vecs[i].ia) : 32'h0);
            chk("ii_valid", i, 32'(II_Valid), 32'(vecs[i].v));
            chk("initi", i, 32'(initi), 32'(vecs[i].ini));
        end

        // Length of the initi window after a fresh reset, bounded at 20 cycles.
        drive(1, 1, 1, 0, 0, 32'h0);
        n_init = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 0, 0, 32'h0);
            if (initi) n_init++;
            else break;
        end
        chk("initi_window_len", 0, 32'(n_init), 32'd4);

        // Two-cycle stall holds PC and IF/ID; then IIWrite=0 alone holds IF/ID while PC advances.
        drive(1, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            chk("stall_pc", i, IMemAddr, 32'hC);
            chk("stall_instr", i, II_Instr, instr_of(32'h8));
            chk("stall_pc4", i, II_PC4, 32'hC);
            chk("stall_valid", i, 32'(II_Valid), 32'd1);
        end
        drive(0, 1, 0, 0, 0, 32'h0);
        chk("iihold_pc", 0, IMemAddr, 32'h10);
        chk("iihold_instr", 0, II_Instr, instr_of(32'h8));
        chk("iihold_pc4", 0, II_PC4, 32'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS subset pipeline. Holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register.
- Obeys the hazard unit's PCWrite, IIWrite and flush controls, and applies the MEM-stage branch redirect.
- Generates the post-reset `initi` window that the hazard unit uses to force PCWrite/IIWrite high while the pipeline contents are still undefined.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INIT_CYCLES, 4, number of clock cycles after reset release during which initi stays asserted (range 1..15).
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or redirect.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  from hazard unit; 0 means hold PC (load-use stall).
- IIWrite  in  1  from hazard unit; 0 means hold IF/ID.
- flush  in  1  from hazard unit; a branch is in ID, EX or MEM.
- PCSrc  in  1  branch taken, resolved in MEM.
- BranchTarget  in  32  redirect target, valid when PCSrc=1.
- IMemData  in  32  combinational instruction-memory read data for IMemAddr.
- IMemAddr  out  32  current PC, driven straight from the PC register.
- II_PC4  out  32  IF/ID register: PC+4 of the latched instruction.
- II_Instr  out  32  IF/ID register: latched instruction word.
- II_Valid  out  1  IF/ID register: 1 means a real instruction, 0 means bubble.
- initi  out  1  initialisation window, fed to the hazard unit.

Behaviour:
- Reset values (the reset branch is taken when reset=1 at a clock edge): PC=RESET_PC; II_Instr=NOP_INSTR; II_PC4=0; II_Valid=0; init counter=INIT_CYCLES; initi=1.
- Init counter:
  - Decrements by 1 each cycle while nonzero and reset=0.
  - initi = (counter != 0), registered.
  - With INIT_CYCLES=4, initi is 1 for exactly 4 cycles after the first edge with reset=0, then stays 0 until the next reset.
  - A reset asserted mid-window reloads the counter.
- PC update, priority high to low:
  1. reset -> RESET_PC.
  2. PCSrc=1 -> BranchTarget.
  3. flush=1 -> hold. The fall-through instruction at branch+4 must not be lost while it is being flushed.
  4. PCWrite=1 -> PC+4.
  5. Otherwise hold.
- IF/ID update, priority high to low:
  1. reset -> as above.
  2. PCSrc=1 or flush=1 -> II_Instr=NOP_INSTR, II_Valid=0, II_PC4 = PC+4 (debug value only).
  3. IIWrite=1 -> II_Instr=IMemData, II_PC4=PC+4, II_Valid=1.
  4. Otherwise hold all three fields.
- Latency: an instruction appears in IF/ID one cycle after its address is on IMemAddr.
- Branch sequence: the branch is in ID at cycle t, and flush is high for t..t+2. The PC holds at branch+4 throughout. At t+2, PCSrc=1 redirects the PC. Normal fetch resumes at t+3 (either the target or branch+4). Three bubbles per branch.
- Simultaneous events:
  - PCSrc overrides PCWrite=0; a redirect is never lost to a stall.
  - flush overrides IIWrite=0, so a bubble is inserted even during a stall.
- Arithmetic: PC+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0; no exception is raised.
- The PC low 2 bits are not checked; a misaligned BranchTarget is passed through unchanged.

Decomposition:
- Shared package: NOP_INSTR, RESET_PC default, and the instruction width constant (32).
- One natural sub-module, if_id_reg: the IF/ID register with write-enable and flush-to-bubble. It can be reused for later stage registers.
- The PC register, adder and init counter stay in fetch_stage.

Test Plan:
- Reset then free-run, PCWrite=IIWrite=1 -> initi high for 4 cycles. IMemAddr steps 0,4,8,… II_Instr follows IMemData one cycle later; II_Valid=1 from the second cycle.
- Load-use stall: PCWrite=IIWrite=0 for 1 cycle with PC=0x10 -> PC stays 0x10 and IF/ID holds the 0x0C instruction. The next cycle fetches 0x14.
- Taken branch: branch at 0x20, flush high 3 cycles, PCSrc=1 with BranchTarget=0x100 in the 3rd -> PC holds at 0x24, then goes to 0x100. II_Valid=0 for 3 cycles, then 0x100's instruction is valid.
- Not-taken branch: same sequence with PCSrc=0 -> PC resumes at 0x24, whose instruction reaches IF/ID with II_Valid=1 and nothing is skipped.
- Simultaneous PCSrc=1 and PCWrite=0 -> PC=BranchTarget. With flush=1 and IIWrite=0 -> IF/ID becomes a bubble.
- Wrap and mid-run reset: PC=0xFFFF_FFFC -> next PC is 0. Asserting reset during the init window -> PC=RESET_PC and initi is held for a full 4 cycles again.
